// File: rtl/wishbone_slave_regfile.sv
// -----------------------------------------------------------------------------
// wishbone_slave_regfile
//
// Wishbone slave holding DEPTH = 2**ADDR_WIDTH 32-bit registers. Each access
// is acknowledged once, WAIT_STATES+1 cycles after the request is sampled.
// Addresses with any bit set above the decoded range are still acked, but
// writes to them are dropped and reads return zero.
//
// Optional feature, enabled by defining WB_SLAVE_REGFILE_INT_EN:
//   register DEPTH-1 becomes a sticky interrupt status register. A write to
//   register k < DEPTH-1 sets status bit k. A write to DEPTH-1 clears the bits
//   written as 1. wb_int_o is the registered OR of the status bits.
//   Without the macro, wb_int_o does not exist and register DEPTH-1 is an
//   ordinary read/write register.
//
// Parameters:
//   ADDR_WIDTH   number of decoded word-address bits (DEPTH = 2**ADDR_WIDTH)
//   WAIT_STATES  extra cycles inserted before ack (0..15)
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-low reset
//   wb_adr_i   in   32  word address
//   wb_dat_i   in   32  write data
//   wb_dat_o   out  32  read data (registered, held until the next read ack)
//   wb_stb_i   in   1   strobe
//   wb_cyc_i   in   1   cycle valid
//   wb_we_i    in   1   1 = write, 0 = read
//   wb_msk_i   in   1   reserved, ignored
//   wb_sel_i   in   1   reserved, ignored
//   wb_ack_o   out  1   single-cycle acknowledge (registered)
//   wb_int_o   out  1   interrupt (only with WB_SLAVE_REGFILE_INT_EN)
//   state_dbg  out  2   current FSM state (0 IDLE, 1 WAIT, 2 ACK, 3 HOLD)
//
// Handshake: a request is taken when wb_cyc_i & wb_stb_i are both high on a
// rising edge in IDLE. The master keeps cyc/stb high until it sees wb_ack_o,
// then must drop wb_stb_i for at least one cycle before the next request;
// dropping cyc or stb while the slave is waiting cancels the access.
// -----------------------------------------------------------------------------
module wishbone_slave_regfile #(
    parameter int ADDR_WIDTH  = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic        wb_msk_i,
    input  logic        wb_sel_i,
    output logic        wb_ack_o,
`ifdef WB_SLAVE_REGFILE_INT_EN
    output logic        wb_int_o,
`endif
    output logic [1:0]  state_dbg
);

    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]            WS_INIT  = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]  cnt;
    logic [31:0] lat_adr;
    logic [31:0] lat_dat;
    logic        lat_we;

    logic [31:0] regs [DEPTH];

    logic                  req_now;
    logic [31:0]           req_adr;
    logic [31:0]           req_dat;
    logic                  req_we;
    logic                  req_in_range;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  acc_fire;
    logic                  do_write;
    logic                  do_read;
    logic [31:0]           rd_data;

    // Reserved inputs are intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, wb_msk_i, wb_sel_i};

    assign req_now   = wb_stb_i && wb_cyc_i;
    assign state_dbg = state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req_now) begin
                    next_state = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Cancellation wins over a counter that has just expired.
                if (!req_now) begin
                    next_state = ST_IDLE;
                end else if (cnt == 4'd1) begin
                    next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                next_state = ST_HOLD;
            end
            ST_HOLD: begin
                // Stay here until the master releases the strobe, so one
                // long strobe can never produce a second ack.
                if (!wb_stb_i) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath decode
    // With no wait states the access completes on the very edge that
    // samples the request, so the bus inputs are used directly in IDLE;
    // otherwise the latched copy is used.
    // ------------------------------------------------------------------
    always_comb begin
        req_adr      = lat_adr;
        req_dat      = lat_dat;
        req_we       = lat_we;
        if (state == ST_IDLE) begin
            req_adr = wb_adr_i;
            req_dat = wb_dat_i;
            req_we  = wb_we_i;
        end
        req_in_range = ~|req_adr[31:ADDR_WIDTH];
        req_idx      = req_adr[ADDR_WIDTH-1:0];
        acc_fire     = (next_state == ST_ACK);
        do_write     = acc_fire && req_we && req_in_range;
        do_read      = acc_fire && !req_we;
        rd_data      = req_in_range ? regs[req_idx] : 32'h0;
    end

    // ------------------------------------------------------------------
    // Request latch and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 4'd0;
            lat_adr <= 32'h0;
            lat_dat <= 32'h0;
            lat_we  <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_now) begin
                cnt     <= WS_INIT;
                lat_adr <= wb_adr_i;
                lat_dat <= wb_dat_i;
                lat_we  <= wb_we_i;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
`ifdef WB_SLAVE_REGFILE_INT_EN
    logic [31:0] status_set;
    assign status_set = 32'd1 << req_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (do_write) begin
            if (req_idx == IDX_LAST) begin
                regs[IDX_LAST] <= regs[IDX_LAST] & ~req_dat;
            end else begin
                regs[req_idx]  <= req_dat;
                regs[IDX_LAST] <= regs[IDX_LAST] | status_set;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (do_write) begin
            regs[req_idx] <= req_dat;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registered bus outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            wb_ack_o <= acc_fire;
            if (do_read) begin
                wb_dat_o <= rd_data;
            end
        end
    end

`ifdef WB_SLAVE_REGFILE_INT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_int_o <= 1'b0;
        end else begin
            wb_int_o <= |regs[IDX_LAST];
        end
    end
`endif

endmodule

// File: tb/tb_wishbone_slave_regfile.sv
// -----------------------------------------------------------------------------
// Bench for wishbone_slave_regfile. Three instances share clock and reset and
// differ only in WAIT_STATES (0, 3, 5). The driver pushes the expected read
// data of every transfer into exp_q; a monitor pops one entry per ack.
// -----------------------------------------------------------------------------
module tb_wishbone_slave_regfile;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Per-instance bus signals
    // ------------------------------------------------------------------
    logic [31:0] adr   [3];
    logic [31:0] dat_w [3];
    logic [31:0] dat_r [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic        msk   [3];
    logic        sel   [3];
    logic        ack   [3];
    logic [1:0]  st    [3];
`ifdef WB_SLAVE_REGFILE_INT_EN
    logic        intr  [3];
`endif

    int ws_of [3] = '{0, 3, 5};

    wishbone_slave_regfile #(.ADDR_WIDTH(4), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst),
        .wb_adr_i(adr[0]), .wb_dat_i(dat_w[0]), .wb_dat_o(dat_r[0]),
        .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]), .wb_we_i(we[0]),
        .wb_msk_i(msk[0]), .wb_sel_i(sel[0]), .wb_ack_o(ack[0]),
`ifdef WB_SLAVE_REGFILE_INT_EN
        .wb_int_o(intr[0]),
`endif
        .state_dbg(st[0])
    );

    wishbone_slave_regfile #(.ADDR_WIDTH(4), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst),
        .wb_adr_i(adr[1]), .wb_dat_i(dat_w[1]), .wb_dat_o(dat_r[1]),
        .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]), .wb_we_i(we[1]),
        .wb_msk_i(msk[1]), .wb_sel_i(sel[1]), .wb_ack_o(ack[1]),
`ifdef WB_SLAVE_REGFILE_INT_EN
        .wb_int_o(intr[1]),
`endif
        .state_dbg(st[1])
    );

    wishbone_slave_regfile #(.ADDR_WIDTH(4), .WAIT_STATES(5)) u_ws5 (
        .clk(clk), .rst(rst),
        .wb_adr_i(adr[2]), .wb_dat_i(dat_w[2]), .wb_dat_o(dat_r[2]),
        .wb_stb_i(stb[2]), .wb_cyc_i(cyc[2]), .wb_we_i(we[2]),
        .wb_msk_i(msk[2]), .wb_sel_i(sel[2]), .wb_ack_o(ack[2]),
`ifdef WB_SLAVE_REGFILE_INT_EN
        .wb_int_o(intr[2]),
`endif
        .state_dbg(st[2])
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // exp_q entry: [34:33] instance, [32] is_read, [31:0] expected read data
    // ------------------------------------------------------------------
    logic [34:0] exp_q [$];
    logic [31:0] last_rd [3];
    logic        prev_ack [3];
    int          ack_cnt [3];
    int          checks;
    int          failures;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic bus_idle(input int inst);
        cyc[inst]   = 1'b0;
        stb[inst]   = 1'b0;
        we[inst]    = 1'b0;
        adr[inst]   = 32'h0;
        dat_w[inst] = 32'h0;
        msk[inst]   = 1'b0;
        sel[inst]   = 1'b0;
    endtask

    // Full transfer: drive the request, wait for ack, check the latency,
    // release the strobe and leave one idle cycle so the slave leaves HOLD.
    task automatic xfer(input string name, input int inst, input logic we_v,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd);
        int lat;
        bit got;
        logic [1:0] tag;
        @(negedge clk);
        tag         = inst[1:0];
        cyc[inst]   = 1'b1;
        stb[inst]   = 1'b1;
        we[inst]    = we_v;
        adr[inst]   = a;
        dat_w[inst] = d;
        msk[inst]   = 1'($urandom_range(0, 1));
        sel[inst]   = 1'($urandom_range(0, 1));
        exp_q.push_back({tag, ~we_v, we_v ? 32'h0 : exp_rd});
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack[inst]) got = 1'b1;
        end
        checks++;
        if (!got || lat != ws_of[inst] + 1) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles (ack seen=%0d) expected %0d",
                     name, lat, got, ws_of[inst] + 1);
        end
        bus_idle(inst);
        @(negedge clk);
    endtask

    task automatic check_all_idle(input string name);
        for (int i = 0; i < 3; i++) begin
            check32({name, " ack"}, {31'h0, ack[i]}, 32'h0);
            check32({name, " dat_o"}, dat_r[i], 32'h0);
            check32({name, " state"}, {30'h0, st[i]}, 32'h0);
`ifdef WB_SLAVE_REGFILE_INT_EN
            check32({name, " int"}, {31'h0, intr[i]}, 32'h0);
`endif
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence with the monitor forked alongside
    // ------------------------------------------------------------------
    initial begin
        int acks_before;
        logic [34:0] e;
        logic [31:0] exp_dat;
        logic [1:0]  itag;

        checks   = 0;
        failures = 0;
        for (int i = 0; i < 3; i++) begin
            bus_idle(i);
            last_rd[i]  = 32'h0;
            prev_ack[i] = 1'b0;
            ack_cnt[i]  = 0;
        end
        rst = 1'b0;

        // Monitor: one scoreboard pop per ack.
        fork
            forever begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    if (ack[i]) begin
                        ack_cnt[i]++;
                        checks++;
                        if (prev_ack[i]) begin
                            failures++;
                            $display("FAIL ack_width inst %0d: ack high %0d cycles in a row, expected 1", i, 2);
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_ack inst %0d: ack=1 expected no ack", i);
                        end else begin
                            e       = exp_q.pop_front();
                            itag    = i[1:0];
                            exp_dat = e[32] ? e[31:0] : last_rd[i];
                            if (e[34:33] != itag || dat_r[i] !== exp_dat) begin
                                failures++;
                                $display("FAIL ack_data inst %0d: got 0x%08h expected 0x%08h (inst %0d)",
                                         i, dat_r[i], exp_dat, e[34:33]);
                            end
                            if (e[32]) last_rd[i] = e[31:0];
                        end
                    end
                    prev_ack[i] = ack[i];
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check_all_idle("reset");
        rst = 1'b1;

        // Write then read, no wait states
        xfer("ws0_wr3", 0, 1'b1, 32'd3, 32'hCAFEBABE, 32'h0);
        xfer("ws0_rd3", 0, 1'b0, 32'd3, 32'h0, 32'hCAFEBABE);

        // Out-of-range address: acked, write dropped, read returns zero
        xfer("oor_wr",  0, 1'b1, 32'h00000103, 32'h12345678, 32'h0);
        xfer("oor_rd3", 0, 1'b0, 32'd3, 32'h0, 32'hCAFEBABE);
        xfer("oor_rd",  0, 1'b0, 32'h00000103, 32'h0, 32'h0);

        // Three wait states
        xfer("ws3_wr5", 1, 1'b1, 32'd5, 32'h00005555, 32'h0);
        xfer("ws3_rd5", 1, 1'b0, 32'd5, 32'h0, 32'h00005555);

        // Abort: cyc dropped two cycles after the request
        acks_before = ack_cnt[2];
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
        adr[2] = 32'd6; dat_w[2] = 32'hDEAD0000;
        repeat (2) @(negedge clk);
        cyc[2] = 1'b0;
        repeat (3) @(negedge clk);
        bus_idle(2);
        repeat (8) @(negedge clk);
        check32("abort ack count", ack_cnt[2], acks_before);
        check32("abort state", {30'h0, st[2]}, 32'h0);
        xfer("abort_rd6", 2, 1'b0, 32'd6, 32'h0, 32'h0);

        // Reset pulsed mid-WAIT
        xfer("ws5_wr1", 2, 1'b1, 32'd1, 32'hA5A5A5A5, 32'h0);
        xfer("ws5_rd1", 2, 1'b0, 32'd1, 32'h0, 32'hA5A5A5A5);
        acks_before = ack_cnt[2];
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
        adr[2] = 32'd7; dat_w[2] = 32'h11111111;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_idle("mid_reset");
        for (int i = 0; i < 3; i++) begin
            bus_idle(i);
            last_rd[i] = 32'h0;
        end
        @(negedge clk);
        rst = 1'b1;
        check32("mid_reset ack count", ack_cnt[2], acks_before);
        xfer("post_rst_rd7", 2, 1'b0, 32'd7, 32'h0, 32'h0);
        xfer("post_rst_rd1", 2, 1'b0, 32'd1, 32'h0, 32'h0);

        // Stream of reads with incrementing address
        for (int k = 0; k < 4; k++) begin
            xfer("stream_wr", 0, 1'b1, 32'(k), 32'(k + 1), 32'h0);
        end
        acks_before = ack_cnt[0];
        for (int k = 0; k < 4; k++) begin
            xfer("stream_rd", 0, 1'b0, 32'(k), 32'h0, 32'(k + 1));
        end
        check32("stream ack count", ack_cnt[0] - acks_before, 32'd4);

`ifdef WB_SLAVE_REGFILE_INT_EN
        // Interrupt status: sticky set, write-1-to-clear
        check32("int after stream", {31'h0, intr[0]}, 32'h1);
        xfer("int_clr_all", 0, 1'b1, 32'd15, 32'hFFFFFFFF, 32'h0);
        check32("int cleared", {31'h0, intr[0]}, 32'h0);
        xfer("int_wr2", 0, 1'b1, 32'd2, 32'h00000077, 32'h0);
        check32("int set", {31'h0, intr[0]}, 32'h1);
        xfer("int_rd15", 0, 1'b0, 32'd15, 32'h0, 32'h00000004);
        xfer("int_w1c", 0, 1'b1, 32'd15, 32'h00000004, 32'h0);
        check32("int after w1c", {31'h0, intr[0]}, 32'h0);
        xfer("int_rd15b", 0, 1'b0, 32'd15, 32'h0, 32'h00000000);
`else
        // Register 15 is plain storage in the default build
        xfer("r15_wr", 0, 1'b1, 32'd15, 32'h0F0F1234, 32'h0);
        xfer("r15_rd", 0, 1'b0, 32'd15, 32'h0, 32'h0F0F1234);
`endif

        repeat (5) @(negedge clk);
        check32("scoreboard drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
